// File: rtl/score_char_encoder_pkg.sv
// score_char_encoder_pkg: character codes, FSM states and glyph helper shared by the score encoder.
package score_char_encoder_pkg;

    localparam logic [5:0] CHAR_SPACE = 6'd36;
    localparam logic [5:0] CHAR_QMARK = 6'd63;

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

    // A digit nibble becomes its own code, or a space when it is a blanked leading zero.
    function automatic logic [5:0] digit_char(input logic [3:0] nibble, input logic blank);
        return blank ? CHAR_SPACE : {2'b00, nibble};
    endfunction

endpackage

// File: rtl/score_char_encoder_bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 when the nibble is 5 or more.
module bcd_add3 (
    input  logic [3:0] nibble,
    output logic [3:0] corrected
);

    assign corrected = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/score_char_encoder.sv
// score_char_encoder: sequential binary-to-BCD conversion of a score into four glyph codes
// with optional leading-zero blanking; outputs only change on the final format step.
module score_char_encoder
    import score_char_encoder_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter bit BLANK = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Score,
    output logic             Busy,
    output logic             Done,
    output logic [5:0]       Char0,
    output logic [5:0]       Char1,
    output logic [5:0]       Char2,
    output logic [5:0]       Char3
);

    localparam int         CW       = $clog2(WIDTH);
    localparam logic [5:0] RST_CHAR = BLANK ? CHAR_SPACE : 6'd0;

    state_t           state, state_next;
    logic [WIDTH-1:0] bin;
    logic [15:0]      bcd, bcd_adj;
    logic [CW-1:0]    cnt;
    logic             last_step;
    logic [3:1]       blank;

    for (genvar i = 0; i < 4; i++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble   (bcd[4*i +: 4]),
            .corrected(bcd_adj[4*i +: 4])
        );
    end

    assign last_step = cnt == CW'(WIDTH - 1);
    assign Busy      = state != IDLE;

    // A nibble is blanked only if it and every nibble above it are zero.
    assign blank[3] = BLANK && (bcd[15:12] == 4'd0);
    assign blank[2] = blank[3] && (bcd[11:8] == 4'd0);
    assign blank[1] = blank[2] && (bcd[7:4] == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = Start ? SHIFT : IDLE;
            SHIFT:   state_next = last_step ? FORMAT : SHIFT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            Done  <= 1'b0;
            Char0 <= 6'd0;
            Char1 <= RST_CHAR;
            Char2 <= RST_CHAR;
            Char3 <= RST_CHAR;
        end else begin
            Done <= state == FORMAT;
            case (state)
                IDLE: begin
                    if (Start) begin
                        bin <= Score;
                        bcd <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
                    cnt        <= cnt + 1'b1;
                end
                default: begin
                    Char0 <= digit_char(bcd[3:0], 1'b0);
                    Char1 <= digit_char(bcd[7:4], blank[1]);
                    Char2 <= digit_char(bcd[11:8], blank[2]);
                    Char3 <= digit_char(bcd[15:12], blank[3]);
                end
            endcase
        end
    end

endmodule

// File: doc/score_char_encoder.md
# score_char_encoder

Converts a binary score into four character codes for the on-screen glyph renderers. It uses a sequential double-dabble (shift-and-add-3) binary-to-BCD conversion and blanks leading zeros with the space code. It sits between the game score registers and the per-digit character renderers, driving their 6-bit `Value` inputs. Outputs hold the last completed result throughout a conversion, so the displayed score never shows intermediate values.

## Interface

Parameters:
- `WIDTH`, 10: binary score width. Legal range is 4..13, so the maximum score is always 9999 or less and fits in 4 decimal digits.
- `BLANK`, 1: leading-zero blanking. 1 replaces leading zeros with the space code; 0 shows all four digits.

Ports:
- `clk`  input  1: system clock. All logic is on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `Start`  input  1: conversion request. Sampled only in IDLE.
- `Score`  input  WIDTH: binary value. Latched on the edge that accepts `Start`.
- `Busy`  output  1: high while in SHIFT or FORMAT.
- `Done`  output  1: one-cycle pulse when the new characters become visible.
- `Char0`  output  6: units digit code.
- `Char1`  output  6: tens digit code.
- `Char2`  output  6: hundreds digit code.
- `Char3`  output  6: thousands digit code.

Character codes: 0..9 are the digits themselves, and 36 is space.

## Operation

State machine with three states: IDLE, SHIFT, FORMAT.
- **IDLE:**
  - When `Start` is 1: latch `Score` into the binary shift register, clear the 16-bit BCD register, clear the counter, and go to SHIFT.
  - When `Start` is 0: stay in IDLE.
- **SHIFT, one step per cycle, WIDTH steps:**
  - Apply the correction first: each BCD nibble that is 5 or more gets 3 added.
  - Then shift {BCD, binary} left by 1, with the binary MSB entering the BCD LSB.
  - Counter increments each step. The step that finishes with counter = WIDTH-1 moves to FORMAT.
- **FORMAT, one cycle:**
  - Nibble i goes to `Chari` (zero-extended to 6 bits).
  - If `BLANK`=1, every nibble above the most significant nonzero nibble becomes 36. `Char0` is never blanked.
  - Assert `Done`, return to IDLE.
- `Start` is ignored while in SHIFT or FORMAT. There is no queueing.
- `Score` changes after acceptance have no effect on the conversion in progress.
- Only the FORMAT edge writes the `Char` outputs.

## Timing

- Reset values:
  - State IDLE; `Busy`=0; `Done`=0.
  - `Char0`=0.
  - `Char1`..`Char3`=36 if `BLANK`=1, otherwise 0 (the display reads "0").
- Latency, with the edge that accepts `Start` numbered edge 0:
  - Edges 1..WIDTH perform the shifts.
  - Edge WIDTH+1 performs FORMAT.
  - New characters and `Done`=1 are visible after edge WIDTH+1, i.e. 11 cycles for WIDTH=10.
- `Busy` is high after edge 0 through edge WIDTH+1. It is low in the cycle where `Done`=1.
- `Done` is high for exactly one cycle.
- Back-to-back conversions: `Start` high while `Done`=1 is accepted, because the state is IDLE. Throughput is one conversion per WIDTH+2 cycles.
- Reset asserted mid-conversion: outputs go to their reset values immediately and asynchronously, and the state returns to IDLE. No `Done` is produced for the aborted conversion.
- Width rules:
  - The counter is ceil(log2(WIDTH)) bits.
  - BCD correction is 4-bit; no nibble exceeds 9 after a shift, given the WIDTH limit.

## Structure

- Shared package:
  - `CHAR_SPACE` = 6'd36.
  - `CHAR_QMARK` = 6'd63 (reserved for the glyph default).
  - State encoding enum {IDLE, SHIFT, FORMAT}.
- Sub-module: `bcd_add3`, a combinational nibble correction (add 3 if the input is 5 or more). Instantiate it 4 times.
- Top level contains the FSM, shift registers, counter, and the blanking/format logic.

## Test plan

- **Reset:** assert `reset` with no `Start` → `Char3`..`Char0` = 36,36,36,0; `Busy`=0; `Done`=0.
- **Score 1023, WIDTH=10, `BLANK`=1:** `Start` pulse → after 11 cycles `Char3`..`Char0` = 1,0,2,3 and `Done` pulses once. `Busy` is high for cycles 1..11.
- **Blanking:**
  - Score 40 → 36,36,4,0.
  - Score 0 → 36,36,36,0.
  - With `BLANK`=0, score 40 → 0,0,4,0.
- **Ignored Start:** Score 7 converting; `Start` re-pulsed with `Score`=999 at cycle 5 → result 36,36,36,7, only one `Done`, and the outputs keep their old values until `Done`.
- **Back-to-back:** `Start` held high continuously with `Score`=12 then 345 → `Done` pulses every 12 cycles, with results 12 then 345.
- **Reset mid-conversion:** assert `reset` at cycle 4 of a conversion of score 500 → outputs immediately take reset values, no `Done`. A later `Start` with score 500 → 36,5,0,0.
